// File: rtl/lsu_seq.sv
// rtl/lsu_seq.sv - load/store burst sequencer ahead of the 64-bit aligner; optional data abort under LSU_DABORT_EN
module lsu_seq #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          GCLK,
    input  logic          nRESET,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_load,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [3:0]    req_beats,
    input  logic [DW-1:0] st_data,
    output logic          st_pop,
    output logic [AW-1:0] DA,
    output logic          DnRW,
    output logic          DnMREQ,
    input  logic          nWAIT,
    output logic [1:0]    addr_low,
    output logic          out_ena,
    output logic          unsigned_byte,
    output logic          unsigned_hw,
    output logic          signed_byte,
    output logic          signed_hw,
    output logic [DW-1:0] ali_data,
    input  logic [DW-1:0] loaded_data,
    output logic          ld_valid,
    output logic [DW-1:0] ld_data,
    output logic          ld_last,
    output logic          busy
`ifdef LSU_DABORT_EN
    ,
    input  logic          DABORT,
    output logic          abort_flag
`endif
);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_ACCESS = 1'b1;

    logic       state;
    logic       load_q;
    logic [1:0] size_q;
    logic       signed_q;
    logic [3:0] cnt;
    logic       abort_now;
    logic       in_access;
    logic       beat_done;
    logic       is_byte;
    logic       is_hw;
    logic       sign_ext;

`ifdef LSU_DABORT_EN
    assign abort_now = DABORT;
`else
    assign abort_now = 1'b0;
`endif

    assign in_access = (state == S_ACCESS);
    assign beat_done = in_access & nWAIT;
    assign is_byte   = (size_q == 2'b01);
    assign is_hw     = (size_q == 2'b10);
    assign sign_ext  = load_q & signed_q;

    // Strobes derive from state so they drop the same cycle the burst ends.
    assign unsigned_byte = in_access & is_byte & ~sign_ext;
    assign signed_byte   = in_access & is_byte &  sign_ext;
    assign unsigned_hw   = in_access & is_hw   & ~sign_ext;
    assign signed_hw     = in_access & is_hw   &  sign_ext;

    assign req_ready = ~in_access;
    assign busy      = in_access;
    assign addr_low  = DA[1:0];
    assign ali_data  = (in_access & ~load_q) ? st_data : '0;
    // A reset landing on a completing beat must not release the store word.
    assign st_pop    = beat_done & ~load_q & ~abort_now & nRESET;

    always_ff @(posedge GCLK) begin
        if (!nRESET) begin
            state    <= S_IDLE;
            load_q   <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            cnt      <= 4'd0;
            DA       <= '0;
            DnRW     <= 1'b0;
            DnMREQ   <= 1'b1;
            out_ena  <= 1'b0;
            ld_data  <= '0;
            ld_valid <= 1'b0;
            ld_last  <= 1'b0;
`ifdef LSU_DABORT_EN
            abort_flag <= 1'b0;
`endif
        end else begin
            ld_valid <= 1'b0;
            ld_last  <= 1'b0;
`ifdef LSU_DABORT_EN
            abort_flag <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        load_q   <= req_load;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        cnt      <= req_beats;
                        DA       <= req_addr;
                        DnRW     <= ~req_load;
                        DnMREQ   <= 1'b0;
                        out_ena  <= ~req_load;
                        state    <= S_ACCESS;
                    end
                end
                default: begin
                    if (beat_done) begin
                        if (abort_now) begin
                            state   <= S_IDLE;
                            DnMREQ  <= 1'b1;
                            DnRW    <= 1'b0;
                            out_ena <= 1'b0;
`ifdef LSU_DABORT_EN
                            abort_flag <= 1'b1;
`endif
                        end else begin
                            if (load_q) begin
                                ld_data  <= loaded_data;
                                ld_valid <= 1'b1;
                                ld_last  <= (cnt == 4'd0);
                            end
                            if (cnt != 4'd0) begin
                                cnt <= cnt - 4'd1;
                                DA  <= DA + AW'(8);
                            end else begin
                                state   <= S_IDLE;
                                DnMREQ  <= 1'b1;
                                DnRW    <= 1'b0;
                                out_ena <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
